// File: rtl/tdc_pkg.sv
// tdc_pkg: constants and types shared by the TDC result link.
// The default link constants live here so that the transmitter in topTDC
// and this receiver are built with the same framing.
`timescale 1ns/1ps
package tdc_pkg;

  // Default link framing shared by both ends of the link.
  localparam int DEF_CLKS_PER_BIT = 87;   // 10 MHz / 115200
  localparam int DEF_BYTES        = 2;
  localparam int DEF_TIMEOUT_BITS = 20;

  // Byte receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver.
// Synchronizes the serial line, finds the start bit, samples eight data bits
// LSB first at mid-bit and validates the stop bit.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   rx             : asynchronous serial line, idles high
//   byte_out[7:0]  : last received byte (valid when byte_ok pulses)
//   byte_ok        : one-cycle pulse, byte received with a good stop bit
//   stop_err       : one-cycle pulse, stop bit sampled low
//   idle           : FSM is in IDLE
//   start_det      : start edge being detected this cycle (IDLE and line low)
`timescale 1ns/1ps
module uart_rx_byte
  import tdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_ok,
  output logic       stop_err,
  output logic       idle,
  output logic       start_det
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic            r_sync1;
  logic            r_sync2;   // synchronized line seen by the FSM
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_byte_ok;
  logic            r_stop_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte_ok  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_byte_ok  <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          // Half-bit wait puts every later sample in the middle of its bit.
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_sync2) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;   // glitch: too short to be a start bit
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          // Sampled mid stop bit, so IDLE is re-entered half a bit early
          // and a back-to-back start edge is never missed.
          if (r_cnt == BIT_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_byte_ok <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_stop_err <= 1'b1;
              r_state    <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_BREAK: begin
          if (r_sync2) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign byte_out  = r_shift;
  assign byte_ok   = r_byte_ok;
  assign stop_err  = r_stop_err;
  assign idle      = (r_state == ST_IDLE);
  assign start_det = (r_state == ST_IDLE) && !r_sync2;

endmodule

// File: rtl/tdc_frame_rx.sv
// tdc_frame_rx: TDC result link receiver.
// Reassembles BYTES little-endian bytes from the serial link into one word.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   rx         : asynchronous serial line, idles high
//   data       : last complete measurement, byte 0 in bits [7:0]
//   data_valid : one-cycle pulse when data updates
//   frame_err  : one-cycle pulse on a bad stop bit or inter-byte timeout
//   busy       : byte FSM active or a partial frame is held
`timescale 1ns/1ps
module tdc_frame_rx
  import tdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int BYTES        = DEF_BYTES,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [8*BYTES-1:0] data,
  output logic               data_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam int IW        = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [7:0]          w_byte;
  logic                w_byte_ok;
  logic                w_stop_err;
  logic                w_idle;
  logic                w_start_det;
  logic [8*BYTES-1:0]  w_shadow_next;

  logic [8*BYTES-1:0]  r_shadow;
  logic [8*BYTES-1:0]  r_data;
  logic [IW-1:0]       r_byte_idx;
  logic [TW-1:0]       r_idle_cnt;
  logic                r_data_valid;
  logic                r_frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (w_byte),
    .byte_ok   (w_byte_ok),
    .stop_err  (w_stop_err),
    .idle      (w_idle),
    .start_det (w_start_det)
  );

  // Shadow with the incoming byte merged in, so the last byte of a frame
  // goes straight to data in the same cycle it is accepted.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_slot
      assign w_shadow_next[gi*8 +: 8] =
        (w_byte_ok && (r_byte_idx == IW'(gi))) ? w_byte : r_shadow[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow     <= '0;
      r_data       <= '0;
      r_byte_idx   <= '0;
      r_idle_cnt   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_byte_ok) begin
        r_shadow   <= w_shadow_next;
        r_idle_cnt <= '0;
        if (r_byte_idx == IW'(BYTES - 1)) begin
          r_data       <= w_shadow_next;
          r_data_valid <= 1'b1;
          r_byte_idx   <= '0;
        end else begin
          r_byte_idx <= r_byte_idx + IW'(1);
        end
      end else if (w_stop_err) begin
        r_frame_err <= 1'b1;
        r_byte_idx  <= '0;
        r_idle_cnt  <= '0;
      end else if (w_start_det || !w_idle || (r_byte_idx == '0)) begin
        // A start detection beats a timeout expiring in the same cycle.
        r_idle_cnt <= '0;
      end else if (r_idle_cnt == TW'(TO_CYCLES - 1)) begin
        r_frame_err <= 1'b1;
        r_byte_idx  <= '0;
        r_idle_cnt  <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + TW'(1);
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = !w_idle || (r_byte_idx != '0);

endmodule

// File: tb/tb_tdc_frame_rx.sv
`timescale 1ns/1ps
module tb_tdc_frame_rx;

  localparam real BIT_NS = 80.0;   // 8 clocks of 10 ns

  logic        clk;
  logic        reset;
  logic        rx;
  logic [15:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  int tests;
  int fails;
  int dv_cnt;
  int fe_cnt;
  int both_cnt;
  logic [15:0] dv_q[$];

  tdc_frame_rx #(
    .CLKS_PER_BIT(8),
    .BYTES(2),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_q.push_back(data);
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] w);
    @(negedge clk);
    send_byte(w[7:0], 1'b1, BIT_NS);
    send_byte(w[15:8], 1'b1, BIT_NS);
    settle(4);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    settle(2);
    tests++; if (data !== 16'h0000) begin fails++; $display("FAIL reset_data got=%h want=0000", data); end
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_dv got=%b want=0", data_valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_fe got=%b want=0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    $display("[TB] reset: data=%h busy=%b", data, busy);
  endtask

  task automatic test_good_frame;
    int dv0, fe0, dv_at, pulses;
    dv0 = dv_cnt; fe0 = fe_cnt; dv_at = -1; pulses = 0;
    @(negedge clk);
    send_byte(8'h34, 1'b1, BIT_NS);
    @(negedge clk);
    fork
      send_byte(8'h12, 1'b1, BIT_NS);
      begin
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (data_valid) begin
            pulses++;
            if (dv_at < 0) dv_at = n;
          end
        end
      end
    join
    settle(2);
    tests++; if (data !== 16'h1234) begin fails++; $display("FAIL good_data got=%h want=1234", data); end
    tests++; if (dv_at !== 79) begin fails++; $display("FAIL good_latency got=%0d want=79", dv_at); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL good_pulses got=%0d want=1", pulses); end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL good_fe got=%0d want=0", fe_cnt - fe0); end
    $display("[TB] good frame: data=%h latency=%0d pulses=%0d dv_total=%0d", data, dv_at, pulses, dv_cnt - dv0);
  endtask

  task automatic test_start_glitch;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    settle(30);
    tests++; if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL glitch_dv got=%0d want=0", dv_cnt - dv0); end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL glitch_fe got=%0d want=0", fe_cnt - fe0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy got=%b want=0", busy); end
    send_frame(16'h00FF);
    tests++; if (data !== 16'h00FF) begin fails++; $display("FAIL glitch_next_data got=%h want=00ff", data); end
    $display("[TB] start glitch: then data=%h", data);
  endtask

  task automatic test_bad_stop;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    @(negedge clk);
    send_byte(8'h55, 1'b0, BIT_NS);
    settle(6);
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL badstop_fe got=%0d want=1", fe_cnt - fe0); end
    tests++; if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL badstop_dv got=%0d want=0", dv_cnt - dv0); end
    send_frame(16'h0201);
    tests++; if (data !== 16'h0201) begin fails++; $display("FAIL badstop_next_data got=%h want=0201", data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badstop_busy got=%b want=0", busy); end
    $display("[TB] bad stop: errors=%0d then data=%h", fe_cnt - fe0, data);
  endtask

  task automatic test_timeout;
    int fe0, fe_early;
    fe0 = fe_cnt;
    @(negedge clk);
    send_byte(8'h99, 1'b1, BIT_NS);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_busy_held got=%b want=1", busy); end
    settle(150);
    fe_early = fe_cnt - fe0;
    tests++; if (fe_early !== 0) begin fails++; $display("FAIL timeout_early got=%0d want=0", fe_early); end
    settle(50);
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL timeout_fe got=%0d want=1", fe_cnt - fe0); end
    tests++; if (data !== 16'h0201) begin fails++; $display("FAIL timeout_data got=%h want=0201", data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got=%b want=0", busy); end
    send_frame(16'hABCD);
    tests++; if (data !== 16'hABCD) begin fails++; $display("FAIL timeout_next_data got=%h want=abcd", data); end
    $display("[TB] timeout: errors=%0d then data=%h", fe_cnt - fe0, data);
  endtask

  task automatic test_reset_mid;
    logic [15:0] d_r;
    logic        dv_r, fe_r, busy_r;
    @(negedge clk);
    fork
      send_byte(8'h78, 1'b1, BIT_NS);
      begin
        repeat (44) @(negedge clk);   // middle of data bit 4
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        d_r = data; dv_r = data_valid; fe_r = frame_err; busy_r = busy;
      end
    join
    tests++; if (d_r !== 16'h0000) begin fails++; $display("FAIL rstmid_data got=%h want=0000", d_r); end
    tests++; if (dv_r !== 1'b0) begin fails++; $display("FAIL rstmid_dv got=%b want=0", dv_r); end
    tests++; if (fe_r !== 1'b0) begin fails++; $display("FAIL rstmid_fe got=%b want=0", fe_r); end
    tests++; if (busy_r !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b want=0", busy_r); end
    // The tail of the interrupted byte can look like a new byte; let any
    // resulting partial frame time out before the next frame.
    settle(350);
    send_frame(16'h5678);
    tests++; if (data !== 16'h5678) begin fails++; $display("FAIL rstmid_next_data got=%h want=5678", data); end
    $display("[TB] reset mid-byte: data after reset=%h then data=%h", d_r, data);
  endtask

  task automatic test_back_to_back;
    int fe0;
    fe0 = fe_cnt;
    dv_q.delete();
    @(negedge clk);
    send_byte(8'h11, 1'b1, 81.6);
    send_byte(8'h22, 1'b1, 81.6);
    send_byte(8'h33, 1'b1, 81.6);
    send_byte(8'h44, 1'b1, 81.6);
    settle(6);
    tests++; if (dv_q.size() !== 2) begin fails++; $display("FAIL b2b_count got=%0d want=2", dv_q.size()); end
    if (dv_q.size() >= 2) begin
      tests++; if (dv_q[0] !== 16'h2211) begin fails++; $display("FAIL b2b_first got=%h want=2211", dv_q[0]); end
      tests++; if (dv_q[1] !== 16'h4433) begin fails++; $display("FAIL b2b_second got=%h want=4433", dv_q[1]); end
    end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL b2b_fe got=%0d want=0", fe_cnt - fe0); end
    $display("[TB] back-to-back +2%%: frames=%0d last data=%h", dv_q.size(), data);
  endtask

  task automatic test_exclusive_pulses;
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL dv_fe_overlap got=%0d want=0", both_cnt); end
    $display("[TB] exclusive pulses: overlaps=%0d", both_cnt);
  endtask

  initial begin
    tests = 0; fails = 0; dv_cnt = 0; fe_cnt = 0; both_cnt = 0;
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_good_frame();
    test_start_glitch();
    test_bad_stop();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_exclusive_pulses();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
